// File: rtl/ao_share_arbiter.sv
// Four-way round-robin arbiter that evaluates (a&b)|(c&d) on the granted operand slice
// and holds the result until it is acknowledged or the ack timeout expires.
// Optional macro AO_ARB_CNT_EN enables the saturating completed-transaction counter on done_cnt.
module ao_share_arbiter #(
  parameter int ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] opnd,
  output logic [3:0]  gnt,
  output logic        res_valid,
  output logic        res_f,
  output logic [1:0]  res_id,
  input  logic        res_ack,
  output logic        to_err,
  output logic [7:0]  done_cnt
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LIMIT = CW'(ACK_TIMEOUT);
  localparam bit TMO_EN = (ACK_TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    win_q, win_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          res_valid_q, res_valid_d;
  logic          res_f_q, res_f_d;
  logic [1:0]    res_id_q, res_id_d;
  logic          to_err_q, to_err_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  logic [1:0]    rr_idx;
  logic [1:0]    rr_cand;
  logic          rr_hit;
  logic [3:0]    win_slice;
  logic          win_f;

  // Scan from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    rr_hit  = 1'b0;
    rr_idx  = ptr_q;
    rr_cand = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      rr_cand = ptr_q + 2'(k);
      if (req[rr_cand]) begin
        rr_hit = 1'b1;
        rr_idx = rr_cand;
      end
    end
  end

  assign win_slice = opnd[{win_q, 2'b00} +: 4];
  assign win_f     = (win_slice[3] & win_slice[2]) | (win_slice[1] & win_slice[0]);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    res_valid_d = res_valid_q;
    res_f_d     = res_f_q;
    res_id_d    = res_id_q;
    to_err_d    = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (rr_hit) begin
          gnt_d   = 4'(4'b0001 << rr_idx);
          win_d   = rr_idx;
          ptr_d   = rr_idx + 2'd1;
          state_d = GRANT;
        end
      end

      GRANT: begin
        gnt_d       = 4'b0000;
        res_f_d     = win_f;
        res_id_d    = win_q;
        res_valid_d = 1'b1;
        tmo_cnt_d   = '0;
        state_d     = RESP;
      end

      RESP: begin
        // An ack on the very edge the counter expires still counts as a completion.
        if (res_ack) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (TMO_EN) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TMO_LIMIT) begin
            res_valid_d = 1'b0;
            to_err_d    = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        gnt_d       = 4'b0000;
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      win_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      res_valid_q <= 1'b0;
      res_f_q     <= 1'b0;
      res_id_q    <= 2'd0;
      to_err_q    <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_f_q     <= res_f_d;
      res_id_q    <= res_id_d;
      to_err_q    <= to_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_f     = res_f_q;
  assign res_id    = res_id_q;
  assign to_err    = to_err_q;

`ifdef AO_ARB_CNT_EN
  logic [7:0] done_cnt_q, done_cnt_d;

  // Only acknowledged completions count; timeouts leave the counter alone.
  always_comb begin
    done_cnt_d = done_cnt_q;
    if ((state_q == RESP) && res_ack && (done_cnt_q != 8'hFF)) begin
      done_cnt_d = done_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q <= 8'd0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;
`else
  assign done_cnt = 8'h00;
`endif

endmodule
